// File: rtl/ipml_fifo_rd_arbiter.sv
// Round-robin burst arbiter draining N_SRC show-ahead FIFO read ports into one
// valid/ready stream, tagging each beat with its source id.
module ipml_fifo_rd_arbiter #(
   parameter int N_SRC     = 4,
   parameter int ID_W      = 2,
   parameter int DATA_W    = 16,
   parameter int BURST_LEN = 32,
   parameter int IDLE_TO   = 8
) (
   input  logic                    rd_clk,
   input  logic                    rd_rst,
   input  logic                    arb_en,
   input  logic [N_SRC*DATA_W-1:0] src_data,
   input  logic [N_SRC-1:0]        src_vld,
   output logic [N_SRC-1:0]        src_rd_en,
   output logic [DATA_W-1:0]       out_data,
   output logic                    out_vld,
   input  logic                    out_rdy,
   output logic [ID_W-1:0]         out_id,
   output logic                    out_last,
   output logic [N_SRC-1:0]        grant,
   output logic                    burst_abort
);

   localparam int              CNT_W      = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_LEN - 1);
   localparam logic [7:0]       IDLE_LIMIT = 8'(IDLE_TO - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   ptr, ptr_nxt, id_nxt;
   logic [N_SRC-1:0]  grant_nxt;
   logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
   logic [7:0]        idle_cnt, idle_cnt_nxt;
   logic              abort_nxt;
   logic [DATA_W-1:0] src_word [N_SRC];
   logic              head_vld, beat, found;
   logic [ID_W-1:0]   pick, cand;

   for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
      assign src_word[g] = src_data[g*DATA_W +: DATA_W];
   end

   // Zero-latency datapath; the reset cycle is masked so no FIFO pop happens in it.
   assign head_vld = src_vld[out_id];
   assign out_data = src_word[out_id];
   assign out_vld  = (state == BURST) & head_vld & ~rd_rst;
   assign beat     = out_vld & out_rdy;
   assign out_last = out_vld & (beat_cnt == LAST_BEAT);

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      src_rd_en = '0;
      if (beat) src_rd_en[out_id] = 1'b1;
   end

   // Search ptr+1, ptr+2, ... so the last granted source has lowest priority.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 1; k <= N_SRC; k++) begin
         cand = ID_W'((int'(ptr) + k) % N_SRC);
         if (!found && src_vld[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      id_nxt       = out_id;
      ptr_nxt      = ptr;
      beat_cnt_nxt = beat_cnt;
      idle_cnt_nxt = idle_cnt;
      abort_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (arb_en && found) begin
               state_nxt    = BURST;
               grant_nxt    = N_SRC'(1) << pick;
               id_nxt       = pick;
               ptr_nxt      = pick;
               beat_cnt_nxt = '0;
               idle_cnt_nxt = '0;
            end
         end
         BURST: begin
            if (beat) begin
               idle_cnt_nxt = '0;
               if (out_last) begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
               end else begin
                  beat_cnt_nxt = beat_cnt + CNT_W'(1);
               end
            end else if (!head_vld) begin
               if (idle_cnt == IDLE_LIMIT) begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
                  abort_nxt = 1'b1;
               end else begin
                  idle_cnt_nxt = idle_cnt + 8'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rd_rst) begin
         state       <= IDLE;
         grant       <= '0;
         out_id      <= '0;
         ptr         <= ID_W'(N_SRC - 1);
         beat_cnt    <= '0;
         idle_cnt    <= '0;
         burst_abort <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         out_id      <= id_nxt;
         ptr         <= ptr_nxt;
         beat_cnt    <= beat_cnt_nxt;
         idle_cnt    <= idle_cnt_nxt;
         burst_abort <= abort_nxt;
      end
   end

endmodule

// File: tb/tb_ipml_fifo_rd_arbiter.sv
// Self-checking bench: queue-backed show-ahead FIFOs feed the arbiter and a
// cycle-level behavioural model of the arbitration rules predicts every output.
module tb_ipml_fifo_rd_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int BL = 32;
   localparam int IT = 8;
   localparam int D  = 512;

   logic            rd_clk = 1'b0;
   logic            rd_rst, arb_en, out_rdy;
   logic [N*DW-1:0] src_data;
   logic [N-1:0]    src_vld, src_rd_en, grant;
   logic [DW-1:0]   out_data;
   logic            out_vld, out_last, burst_abort;
   logic [1:0]      out_id;

   ipml_fifo_rd_arbiter #(.N_SRC(N), .ID_W(2), .DATA_W(DW), .BURST_LEN(BL), .IDLE_TO(IT)) dut (
      .rd_clk(rd_clk), .rd_rst(rd_rst), .arb_en(arb_en), .src_data(src_data),
      .src_vld(src_vld), .src_rd_en(src_rd_en), .out_data(out_data), .out_vld(out_vld),
      .out_rdy(out_rdy), .out_id(out_id), .out_last(out_last), .grant(grant),
      .burst_abort(burst_abort)
   );

   always #5 rd_clk = ~rd_clk;

   // FIFO contents as ring buffers
   logic [DW-1:0] mem [N][D];
   int            wr [N];
   int            rd [N];

   bit rst_drive = 1'b1, en_drive = 1'b1, rdy_random = 1'b0;
   int checks = 0, errors = 0, cyc = 0;

   // behavioural model: owner = source holding the grant, -1 when none
   int m_owner = -1, m_id = 0, m_ptr = N - 1, m_beats = 0, m_idle = 0;
   bit m_abort = 1'b0;
   logic [28:0] exp_v, obs_v;

   // observed burst history
   int grant_log[$], beats_log[$], last_log[$];
   int abort_cnt = 0, cur_beats = 0, cur_last = 0;
   logic [N-1:0] prev_grant = '0;

   function automatic int occ(input int s);
      return wr[s] - rd[s];
   endfunction

   task automatic push(input int s, input int n);
      for (int j = 0; j < n; j++) begin
         mem[s][wr[s] % D] = 16'($urandom);
         wr[s]++;
      end
   endtask

   task automatic tick();
      int o, sel;
      logic e_vld, e_last;
      logic [N-1:0] e_rd, e_grant;
      logic [DW-1:0] e_data;
      @(negedge rd_clk);
      cyc++;
      rd_rst = rst_drive;
      arb_en = en_drive;
      for (int i = 0; i < N; i++) begin
         src_vld[i] = occ(i) > 0;
         src_data[i*DW +: DW] = src_vld[i] ? mem[i][rd[i] % D] : 16'($urandom);
      end
      out_rdy = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      o       = (m_owner < 0) ? 0 : m_owner;
      e_vld   = (m_owner >= 0) && !rd_rst && src_vld[o];
      e_data  = e_vld ? mem[o][rd[o] % D] : '0;
      e_last  = e_vld && (m_beats == BL - 1);
      e_rd    = (e_vld && out_rdy) ? N'(1) << o : '0;
      e_grant = (m_owner >= 0) ? N'(1) << o : '0;
      exp_v   = {e_rd, e_data, e_vld, 2'(m_id), e_last, e_grant, m_abort};
      obs_v   = {src_rd_en, (e_vld ? out_data : 16'h0), out_vld, out_id, out_last, grant, burst_abort};
      // history from observed outputs
      if (grant != 0 && prev_grant == 0) begin
         for (int i = 0; i < N; i++) if (grant[i]) grant_log.push_back(i);
         cur_beats = 0;
         cur_last  = 0;
      end
      if (out_vld && out_rdy) begin
         cur_beats++;
         if (out_last) cur_last = 1;
      end
      if (grant == 0 && prev_grant != 0) begin
         beats_log.push_back(cur_beats);
         last_log.push_back(cur_last);
      end
      if (burst_abort === 1'b1) abort_cnt++;
      prev_grant = grant;
      // model advances to the next cycle
      if (rd_rst) begin
         m_owner = -1; m_id = 0; m_ptr = N - 1; m_beats = 0; m_idle = 0; m_abort = 0;
      end else if (m_owner < 0) begin
         m_abort = 0;
         sel = -1;
         for (int k = 1; k <= N; k++)
            if (sel < 0 && src_vld[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
         if (arb_en && sel >= 0) begin
            m_owner = sel; m_id = sel; m_ptr = sel; m_beats = 0; m_idle = 0;
         end
      end else begin
         m_abort = 0;
         if (src_vld[o] && out_rdy) begin
            m_idle = 0;
            if (m_beats == BL - 1) m_owner = -1;
            else m_beats++;
         end else if (!src_vld[o]) begin
            if (m_idle == IT - 1) begin
               m_owner = -1;
               m_abort = 1;
            end else begin
               m_idle++;
            end
         end
      end
      // the FIFOs pop on what the DUT actually asserted
      for (int i = 0; i < N; i++) if (src_rd_en[i] && occ(i) > 0) rd[i]++;
   endtask

   task automatic do_reset();
      rst_drive = 1'b1;
      for (int i = 0; i < N; i++) rd[i] = wr[i];
      repeat (2) tick();
      rst_drive = 1'b0;
      grant_log.delete();
      beats_log.delete();
      last_log.delete();
      abort_cnt = 0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) begin wr[i] = 0; rd[i] = 0; push(i, 40); end
      rst_drive = 1'b1;
      tick();
      repeat (3) begin
         tick();
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            if (errors <= 40) $display("FAIL reset cyc %0d got %h exp %h", cyc, obs_v, exp_v);
         end
      end
      checks++;
      if ({grant, out_vld, src_rd_en, out_id, out_last, burst_abort} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h exp 0", {grant, out_vld, src_rd_en, out_id, out_last, burst_abort});
      end
   endtask

   task automatic test_first_burst();
      int g_cyc = -1;
      rst_drive = 1'b0;
      for (int c = 0; c < 80; c++) begin
         tick();
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            if (errors <= 40) $display("FAIL first_burst cyc %0d got %h exp %h", cyc, obs_v, exp_v);
         end
         if (g_cyc < 0 && grant == 4'b0001) g_cyc = c;
      end
      checks++;
      if (g_cyc != 1) begin errors++; $display("FAIL first_grant_cycle got %0d exp 1", g_cyc); end
      checks++;
      if (beats_log.size() < 1 || beats_log[0] != 32 || last_log[0] != 1) begin
         errors++;
         $display("FAIL first_burst_len got %0d bursts exp 32 beats with last", beats_log.size());
      end
      checks++;
      if (grant_log.size() < 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
         errors++;
         $display("FAIL first_grant_order got %0d grants exp 0 then 1", grant_log.size());
      end
   endtask

   task automatic test_all_valid();
      int exp_order [5] = '{0, 1, 2, 3, 0};
      int c;
      do_reset();
      for (int i = 0; i < N; i++) push(i, 80);
      for (c = 0; c < 400 && grant_log.size() < 5; c++) begin
         tick();
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            if (errors <= 40) $display("FAIL all_valid cyc %0d got %h exp %h", cyc, obs_v, exp_v);
         end
      end
      checks++;
      if (grant_log.size() < 5) begin
         errors++;
         $display("FAIL all_valid_timeout got %0d grants exp 5", grant_log.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            checks++;
            if (grant_log[k] != exp_order[k]) begin
               errors++;
               $display("FAIL all_valid_order idx %0d got %0d exp %0d", k, grant_log[k], exp_order[k]);
            end
         end
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (beats_log[k] != 32 || last_log[k] != 1) begin
               errors++;
               $display("FAIL all_valid_len idx %0d got %0d/%0d exp 32/1", k, beats_log[k], last_log[k]);
            end
         end
      end
   endtask

   task automatic test_random_rdy();
      int c;
      do_reset();
      for (int i = 0; i < N; i++) push(i, $urandom_range(20, 60));
      rdy_random = 1'b1;
      for (c = 0; c < 2000 && (occ(0) + occ(1) + occ(2) + occ(3)) > 0; c++) begin
         tick();
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            if (errors <= 40) $display("FAIL random_rdy cyc %0d got %h exp %h", cyc, obs_v, exp_v);
         end
         checks++;
         if (src_rd_en != 0 && !out_rdy) begin
            errors++;
            $display("FAIL pop_without_rdy cyc %0d got %b exp 0000", cyc, src_rd_en);
         end
      end
      rdy_random = 1'b0;
      checks++;
      if ((occ(0) + occ(1) + occ(2) + occ(3)) != 0) begin
         errors++;
         $display("FAIL random_rdy_drain got %0d words left exp 0", occ(0) + occ(1) + occ(2) + occ(3));
      end
      repeat (12) tick();
   endtask

   task automatic test_timeout();
      int c, last_c = -1, abort_c = -1;
      do_reset();
      push(1, 5);
      push(2, 10);
      for (c = 0; c < 200 && grant_log.size() < 2; c++) begin
         tick();
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            if (errors <= 40) $display("FAIL timeout cyc %0d got %h exp %h", cyc, obs_v, exp_v);
         end
         if (out_vld && out_rdy && out_id == 2'd1) last_c = c;
         if (burst_abort && abort_c < 0) abort_c = c;
      end
      checks++;
      if (grant_log.size() < 2 || grant_log[0] != 1 || grant_log[1] != 2) begin
         errors++;
         $display("FAIL timeout_grants got %0d grants exp 1 then 2", grant_log.size());
      end
      checks++;
      if (beats_log.size() < 1 || beats_log[0] != 5 || last_log[0] != 0) begin
         errors++;
         $display("FAIL timeout_burst got %0d bursts exp 5 beats without last", beats_log.size());
      end
      checks++;
      if (abort_cnt != 1 || abort_c - last_c != 9) begin
         errors++;
         $display("FAIL timeout_abort got cnt %0d gap %0d exp cnt 1 gap 9", abort_cnt, abort_c - last_c);
      end
   endtask

   task automatic test_lone_source();
      int exp_len [3] = '{32, 32, 6};
      int exp_last [3] = '{1, 1, 0};
      int c;
      do_reset();
      push(2, 70);
      for (c = 0; c < 300 && beats_log.size() < 3; c++) begin
         tick();
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            if (errors <= 40) $display("FAIL lone cyc %0d got %h exp %h", cyc, obs_v, exp_v);
         end
      end
      checks++;
      if (beats_log.size() < 3) begin
         errors++;
         $display("FAIL lone_timeout got %0d bursts exp 3", beats_log.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (beats_log[k] != exp_len[k] || last_log[k] != exp_last[k] || grant_log[k] != 2) begin
               errors++;
               $display("FAIL lone_burst idx %0d got %0d/%0d src %0d exp %0d/%0d src 2",
                        k, beats_log[k], last_log[k], grant_log[k], exp_len[k], exp_last[k]);
            end
         end
      end
      checks++;
      if (abort_cnt != 1) begin errors++; $display("FAIL lone_abort got %0d exp 1", abort_cnt); end
      // arb_en dropped mid-burst: burst completes, then no further grant
      push(2, 40);
      for (c = 0; c < 100 && !(grant_log.size() >= 4 && cur_beats >= 10); c++) begin
         tick();
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            if (errors <= 40) $display("FAIL arb_en cyc %0d got %h exp %h", cyc, obs_v, exp_v);
         end
      end
      en_drive = 1'b0;
      repeat (80) begin
         tick();
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            if (errors <= 40) $display("FAIL arb_en_off cyc %0d got %h exp %h", cyc, obs_v, exp_v);
         end
      end
      checks++;
      if (beats_log.size() != 4 || beats_log[3] != 32 || last_log[3] != 1 || grant_log.size() != 4) begin
         errors++;
         $display("FAIL arb_en_finish got %0d bursts %0d grants exp 4/4 ending with 32 beats",
                  beats_log.size(), grant_log.size());
      end
      checks++;
      if (occ(2) != 8) begin errors++; $display("FAIL arb_en_left got %0d exp 8", occ(2)); end
      en_drive = 1'b1;
   endtask

   task automatic test_reset_mid_burst();
      int c;
      do_reset();
      push(3, 40);
      for (c = 0; c < 100 && !(grant == 4'b1000 && cur_beats >= 10); c++) begin
         tick();
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            if (errors <= 40) $display("FAIL mid_reset cyc %0d got %h exp %h", cyc, obs_v, exp_v);
         end
      end
      push(0, 5);
      rst_drive = 1'b1;
      tick();
      checks++;
      if (src_rd_en !== 4'b0000 || out_vld !== 1'b0) begin
         errors++;
         $display("FAIL reset_cycle_pop got %b/%b exp 0000/0", src_rd_en, out_vld);
      end
      tick();
      checks++;
      if ({grant, out_vld, src_rd_en, out_id, out_last, burst_abort} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs got %h exp 0", {grant, out_vld, src_rd_en, out_id, out_last, burst_abort});
      end
      checks++;
      if (occ(3) != 30) begin errors++; $display("FAIL mid_reset_fifo got %0d exp 30", occ(3)); end
      rst_drive = 1'b0;
      grant_log.delete();
      for (c = 0; c < 20 && grant_log.size() < 1; c++) begin
         tick();
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            if (errors <= 40) $display("FAIL post_reset cyc %0d got %h exp %h", cyc, obs_v, exp_v);
         end
      end
      checks++;
      if (grant_log.size() < 1 || grant_log[0] != 0) begin
         errors++;
         $display("FAIL post_reset_grant got %0d grants exp first grant to 0", grant_log.size());
      end
   endtask

   initial begin
      rd_rst = 1'b1; arb_en = 1'b0; out_rdy = 1'b1; src_vld = '0; src_data = '0;
      test_reset();
      test_first_burst();
      test_all_valid();
      test_random_rdy();
      test_timeout();
      test_lone_source();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
